seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 198 +++++++++++++++++++
 tb/tb_seq_alu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Brief    : Handshaked ALU, single-cycle ops plus multi-cycle restoring divide
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int             c_CW       = SHW + 1;
   localparam logic [c_CW-1:0] c_CNT_DONE = c_CW'(WIDTH);

   localparam logic [3:0] c_OP_ADD  = 4'h0;
   localparam logic [3:0] c_OP_SUB  = 4'h1;
   localparam logic [3:0] c_OP_MULT = 4'h2;
   localparam logic [3:0] c_OP_DIV  = 4'h3;
   localparam logic [3:0] c_OP_LSL  = 4'h4;
   localparam logic [3:0] c_OP_LSR  = 4'h5;
   localparam logic [3:0] c_OP_ROL  = 4'h6;
   localparam logic [3:0] c_OP_ROR  = 4'h7;
   localparam logic [3:0] c_OP_AND  = 4'h8;
   localparam logic [3:0] c_OP_OR   = 4'h9;
   localparam logic [3:0] c_OP_XOR  = 4'ha;
   localparam logic [3:0] c_OP_NOR  = 4'hb;
   localparam logic [3:0] c_OP_NAND = 4'hc;
   localparam logic [3:0] c_OP_XNOR = 4'hd;
   localparam logic [3:0] c_OP_GT   = 4'he;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_DIV  = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic [WIDTH-1:0]  r_result, w_result_nxt;
   logic [3:0]        r_flags, w_flags_nxt;
   logic [WIDTH-1:0]  r_quo, w_quo_nxt;
   logic [WIDTH-1:0]  r_rem, w_rem_nxt;
   logic [WIDTH-1:0]  r_dvs, w_dvs_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [SHW-1:0]    w_amt;
   logic [SHW-1:0]    w_inv_amt;
   logic [WIDTH-1:0]  w_alu_res;
   logic              w_alu_c, w_alu_v, w_alu_dz;
   logic              w_accept;
   logic              w_long_div;
   logic [WIDTH:0]    w_rem_sh;
   logic              w_rem_ge;
   logic [WIDTH-1:0]  w_rem_sub;

   assign w_sum     = {1'b0, a} + {1'b0, b};
   assign w_diff    = {1'b0, a} - {1'b0, b};
   assign w_prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign w_amt     = b[SHW-1:0];
   // Complementary rotate distance; wraps to 0 when w_amt is 0, giving a | a = a.
   assign w_inv_amt = -w_amt;

   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      w_alu_dz  = 1'b0;
      case (sel)
         c_OP_ADD: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_SUB: begin
            w_alu_res = w_diff[WIDTH-1:0];
            w_alu_c   = w_diff[WIDTH];
            w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_MULT: begin
            w_alu_res = w_prod[WIDTH-1:0];
            w_alu_c   = |w_prod[2*WIDTH-1:WIDTH];
         end
         c_OP_DIV: begin
            w_alu_res = '1;
            w_alu_dz  = 1'b1;
         end
         c_OP_LSL:  w_alu_res = a << w_amt;
         c_OP_LSR:  w_alu_res = a >> w_amt;
         c_OP_ROL:  w_alu_res = (a << w_amt) | (a >> w_inv_amt);
         c_OP_ROR:  w_alu_res = (a >> w_amt) | (a << w_inv_amt);
         c_OP_AND:  w_alu_res = a & b;
         c_OP_OR:   w_alu_res = a | b;
         c_OP_XOR:  w_alu_res = a ^ b;
         c_OP_NOR:  w_alu_res = ~(a | b);
         c_OP_NAND: w_alu_res = ~(a & b);
         c_OP_XNOR: w_alu_res = ~(a ^ b);
         c_OP_GT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
         default:   w_alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      endcase
   end

   assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !rst;
   assign w_accept   = in_valid && in_ready;
   assign w_long_div = (sel == c_OP_DIV) && (b != '0);

   // Restoring step: shift next dividend bit into remainder, subtract if it fits.
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_rem_ge  = w_rem_sh >= {1'b0, r_dvs};
   assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dvs;

   always_comb begin
      w_state_nxt     = r_state;
      w_out_valid_nxt = r_out_valid;
      w_result_nxt    = r_result;
      w_flags_nxt     = r_flags;
      w_quo_nxt       = r_quo;
      w_rem_nxt       = r_rem;
      w_dvs_nxt       = r_dvs;
      w_cnt_nxt       = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_long_div) begin
                  w_state_nxt     = S_DIV;
                  w_out_valid_nxt = 1'b0;
                  w_quo_nxt       = a;
                  w_rem_nxt       = '0;
                  w_dvs_nxt       = b;
                  w_cnt_nxt       = '0;
               end else begin
                  w_out_valid_nxt = 1'b1;
                  w_result_nxt    = w_alu_res;
                  w_flags_nxt     = {w_alu_dz, w_alu_v, w_alu_c, (w_alu_res == '0)};
               end
            end else if (r_out_valid && out_ready) begin
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            if (r_cnt == c_CNT_DONE) begin
               w_state_nxt     = S_IDLE;
               w_out_valid_nxt = 1'b1;
               w_result_nxt    = r_quo;
               w_flags_nxt     = {3'b000, (r_quo == '0)};
               w_cnt_nxt       = '0;
            end else begin
               w_rem_nxt = w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
               w_quo_nxt = {r_quo[WIDTH-2:0], w_rem_ge};
               w_cnt_nxt = r_cnt + c_CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_result    <= w_result_nxt;
         r_flags     <= w_flags_nxt;
         r_quo       <= w_quo_nxt;
         r_rem       <= w_rem_nxt;
         r_dvs       <= w_dvs_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module   : tb_seq_alu
//  Brief    : Scoreboard bench for seq_alu (WIDTH=16)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic [3:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int out_cnt  = 0;
   int run_len  = 0;
   int last_out = -10;
   logic [23:0] q[$];

   seq_alu #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: returns {sel, dz, ovf, carry, zero, result}
   function automatic logic [23:0] model(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y);
      int ux = int'(x);
      int uy = int'(y);
      int sx = int'($signed(x));
      int sy = int'($signed(y));
      int amt = uy & 15;
      int r = 0;
      longint p;
      bit c = 0, v = 0, d = 0;
      case (s)
         4'h0: begin r = ux + uy; c = r > 65535; v = (sx + sy > 32767) || (sx + sy < -32768); end
         4'h1: begin r = ux - uy; c = ux < uy; v = (sx - sy > 32767) || (sx - sy < -32768); end
         4'h2: begin p = longint'(ux) * longint'(uy); r = int'(p & 65535); c = (p >> 16) != 0; end
         4'h3: if (uy == 0) begin r = 65535; d = 1; end else r = ux / uy;
         4'h4: r = ux << amt;
         4'h5: r = ux >> amt;
         4'h6: r = (ux << amt) | (ux >> (16 - amt));
         4'h7: r = (ux >> amt) | (ux << (16 - amt));
         4'h8: r = ux & uy;
         4'h9: r = ux | uy;
         4'ha: r = ux ^ uy;
         4'hb: r = ~(ux | uy);
         4'hc: r = ~(ux & uy);
         4'hd: r = ~(ux ^ uy);
         4'he: r = (sx > sy) ? 1 : 0;
         default: r = (ux == uy) ? 1 : 0;
      endcase
      r = r & 65535;
      return {s, d, v, c, (r == 0), 16'(r)};
   endfunction

   // Scoreboard: push on accept, pop and compare on output handshake
   always @(negedge clk) begin
      logic [23:0] e;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 32'(1), 32'(0));
            end else begin
               e = q.pop_front();
               check($sformatf("res_op%0h", e[23:20]), 32'(result), 32'(e[15:0]));
               check($sformatf("flg_op%0h", e[23:20]), 32'(flags), 32'(e[19:16]));
            end
            out_cnt++;
            run_len  = (last_out == cyc - 1) ? run_len + 1 : 1;
            last_out = cyc;
         end
         if (in_valid && in_ready) q.push_back(model(sel, a, b));
      end
   end

   task automatic send(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y);
      bit ok = 0;
      in_valid = 1'b1; sel = s; a = x; b = y;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("send_timeout", 32'(1), 32'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_now(input string tag, input logic [15:0] r, input logic [3:0] f);
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_res"},   32'(result),    32'(r));
      check({tag, "_flg"},   32'(flags),     32'(f));
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) return;
      end
      check("drain_timeout", 32'(q.size()), 32'(0));
   endtask

   initial begin
      int n, bad, ibad, c0;
      logic [15:0] x16;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_result",    32'(result),    32'(0));
      check("rst_flags",     32'(flags),     32'(0));
      check("idle_in_ready", 32'(in_ready),  32'(1));

      // ADD boundaries, latency 1
      @(posedge clk); #1;
      send(4'h0, 16'hFFFF, 16'h0001); expect_now("add_carry", 16'h0000, 4'b0011);
      send(4'h0, 16'h7FFF, 16'h0001); expect_now("add_ovf",   16'h8000, 4'b0100);
      send(4'h1, 16'h0003, 16'h0005); expect_now("sub_borrow", 16'hFFFE, 4'b0010);
      drain();

      // Long divide: in_ready low, result exactly 17 edges after accept
      @(posedge clk); #1;
      send(4'h3, 16'd100, 16'd7);
      in_valid = 1'b1; sel = 4'h0; a = 16'h1111; b = 16'h2222;
      n = 0; ibad = 0;
      if (in_ready) ibad++;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) break;
         if (in_ready) ibad++;
      end
      in_valid = 1'b0;
      check("div_latency", 32'(n), 32'(17));
      check("div_in_ready_low", 32'(ibad), 32'(0));
      check("div_result", 32'(result), 32'(14));
      drain();

      @(posedge clk); #1;
      send(4'h3, 16'h1234, 16'h0000); expect_now("div_zero", 16'hFFFF, 4'b1000);
      drain();

      // Backpressure on MULT
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(4'h2, 16'h0100, 16'h0100);
      bad = 0; ibad = 0;
      repeat (5) begin
         @(negedge clk);
         if (!out_valid || result !== 16'h0000 || flags !== 4'b0011) bad++;
         if (in_ready) ibad++;
      end
      check("bp_stable", 32'(bad), 32'(0));
      check("bp_in_ready", 32'(ibad), 32'(0));
      @(posedge clk); #1;
      c0 = out_cnt;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_consumed", 32'(out_cnt - c0), 32'(1));
      check("bp_cleared", 32'(out_valid), 32'(0));
      @(negedge clk);
      check("bp_once", 32'(out_cnt - c0), 32'(1));

      // Streaming eight back-to-back ops
      repeat (3) @(posedge clk); #1;
      c0 = out_cnt;
      send(4'h6, 16'h8001, 16'h0001);
      send(4'he, 16'hFFFF, 16'h0001);
      send(4'hf, 16'h1234, 16'h1234);
      send(4'ha, 16'hA5A5, 16'h0FF0);
      send(4'h7, 16'h1234, 16'h0000);
      send(4'hc, 16'hFFFF, 16'hFFFF);
      send(4'h5, 16'h8000, 16'h000F);
      send(4'hb, 16'h0000, 16'h0000);
      drain();
      check("stream_count", 32'(out_cnt - c0), 32'(8));
      check("stream_run", 32'(run_len), 32'(8));

      // Reset in the middle of a divide
      @(posedge clk); #1;
      send(4'h3, 16'hFFFF, 16'h0003);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 32'(in_ready), 32'(1));
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      check("abort_no_out", 32'(bad), 32'(0));
      @(posedge clk); #1;
      send(4'h0, 16'h1234, 16'h0FF0); expect_now("post_abort_add", 16'h2224, 4'b0000);
      drain();

      // Random ops, all functions
      @(posedge clk); #1;
      for (int i = 0; i < 30; i++) begin
         x16 = 16'($urandom);
         send(4'($urandom_range(0, 15)), x16, (i % 5 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom));
      end
      drain();
      check("final_queue_empty", 32'(q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
